// File: rtl/reg_writeback_unit_pkg.sv
// Shared pipeline definitions for the register write-back slice: data and
// register-address widths, pending-counter sizing, and the result selector.
package reg_writeback_unit_pkg;

  localparam int WIDTH = 16;
  localparam int AW    = 3;
  localparam int CNT_W = 2;
  localparam int NREG  = 1 << AW;

  typedef logic [WIDTH-1:0] data_t;
  typedef logic [AW-1:0]    reg_addr_t;
  typedef logic [CNT_W-1:0] pend_cnt_t;

  localparam pend_cnt_t CNT_MAX = {CNT_W{1'b1}};

  // Write-back result select: load data when mem_to_reg, else ALU result.
  function automatic data_t wb_select(input logic to_reg, input data_t load_data,
                                      input data_t alu_result);
    return to_reg ? load_data : alu_result;
  endfunction

endpackage

// File: rtl/reg_writeback_unit_if.sv
// Pipeline-side bus of the write-back unit: issue handshake, decode operand
// addresses, MEM-stage result, and the register-file write port.
interface reg_writeback_unit_if;
  import reg_writeback_unit_pkg::*;

  logic      flush;
  logic      issue_valid;
  logic      issue_reg_write;
  reg_addr_t issue_rd;
  logic      issue_ready;
  reg_addr_t rs;
  reg_addr_t rd;
  logic      rs_used;
  logic      rd_used;
  logic      stall;
  logic      mem_valid;
  logic      mem_reg_write;
  reg_addr_t mem_rd;
  logic      mem_to_reg;
  data_t     mem_alu_result;
  data_t     mem_load_data;
  logic      op_reg_write;
  reg_addr_t address_for_write;
  data_t     data_for_write;
  logic      fwd_a;
  logic      fwd_b;

  modport master (
    output flush, issue_valid, issue_reg_write, issue_rd, rs, rd, rs_used, rd_used,
           mem_valid, mem_reg_write, mem_rd, mem_to_reg, mem_alu_result, mem_load_data,
    input  issue_ready, stall, op_reg_write, address_for_write, data_for_write, fwd_a, fwd_b
  );

  modport slave (
    input  flush, issue_valid, issue_reg_write, issue_rd, rs, rd, rs_used, rd_used,
           mem_valid, mem_reg_write, mem_rd, mem_to_reg, mem_alu_result, mem_load_data,
    output issue_ready, stall, op_reg_write, address_for_write, data_for_write, fwd_a, fwd_b
  );

endinterface

// File: rtl/reg_writeback_unit_checker.sv
// Protocol checker: a commit must never hit a register with no pending write.
module reg_writeback_unit_checker
  import reg_writeback_unit_pkg::*;
(
  input logic            clock,
  input logic            reset,
  input logic            flush,
  input logic            op_reg_write,
  input reg_addr_t       address_for_write,
  input logic [NREG-1:0] cnt_nz
);

  // Retire against a zero counter means issue tracking lost a write.
  always @(posedge clock) begin
    if (reset && !flush && op_reg_write) begin
      assert (cnt_nz[address_for_write])
        else $error("retire to r%0d with zero pending count", address_for_write);
    end
  end

endmodule

// File: rtl/reg_writeback_unit_counter_bank.sv
// pending_counter_bank: one saturating up/down counter per register, counting
// writes issued but not yet committed. Increment and decrement of the same
// register in one cycle cancel; decrement at zero holds at zero.
module pending_counter_bank
  import reg_writeback_unit_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            inc_en,
  input  reg_addr_t       inc_addr,
  input  logic            dec_en,
  input  reg_addr_t       dec_addr,
  output logic [NREG-1:0] cnt_nz,
  output logic [NREG-1:0] cnt_one,
  output logic [NREG-1:0] cnt_max
);

  pend_cnt_t cnt_r    [NREG];
  pend_cnt_t cnt_next_s [NREG];

  // Next-count computation per register with saturation at both ends.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      logic inc_s;
      logic dec_s;
      inc_s = inc_en && (inc_addr == reg_addr_t'(i));
      dec_s = dec_en && (dec_addr == reg_addr_t'(i)) && (cnt_r[i] != pend_cnt_t'(0));
      if (inc_s && !dec_s && (cnt_r[i] != CNT_MAX)) begin
        cnt_next_s[i] = cnt_r[i] + pend_cnt_t'(1);
      end else if (dec_s && !inc_s) begin
        cnt_next_s[i] = cnt_r[i] - pend_cnt_t'(1);
      end else begin
        cnt_next_s[i] = cnt_r[i];
      end
    end
  end

  // Counter state: reset and flush zero every counter, reset first.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NREG; i++) begin
      if (!reset) begin
        cnt_r[i] <= pend_cnt_t'(0);
      end else if (clear) begin
        cnt_r[i] <= pend_cnt_t'(0);
      end else begin
        cnt_r[i] <= cnt_next_s[i];
      end
    end
  end

  // Per-register status flags for hazard and issue-throttle logic.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_nz[i]  = (cnt_r[i] != pend_cnt_t'(0));
      cnt_one[i] = (cnt_r[i] == pend_cnt_t'(1));
      cnt_max[i] = (cnt_r[i] == CNT_MAX);
    end
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: MEM/WB pipeline register, result select, register-file
// write drive, pending-write scoreboard and decode operand-hazard stall.
// Optional feature macro: WB_BYPASS_EN (clears the hazard when the value being
// written back this cycle is the youngest pending write, and raises fwd_a/fwd_b).
module reg_writeback_unit
  import reg_writeback_unit_pkg::*;
(
  input logic                 clock,
  input logic                 reset,
  reg_writeback_unit_if.slave bus
);

  logic            wb_valid_r;
  reg_addr_t       wb_rd_r;
  data_t           wb_data_r;
  logic [NREG-1:0] cnt_nz_s;
  logic [NREG-1:0] cnt_one_s;
  logic [NREG-1:0] cnt_max_s;
  logic            haz_s_s;
  logic            haz_d_s;
  logic            stall_s;
  logic            issue_ready_s;
  logic            issue_fire_s;
  logic            fwd_a_s;
  logic            fwd_b_s;

  // MEM/WB register: flush discards the instruction about to be written.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wb_valid_r <= 1'b0;
      wb_rd_r    <= reg_addr_t'(0);
      wb_data_r  <= data_t'(0);
    end else if (bus.flush) begin
      wb_valid_r <= 1'b0;
      wb_rd_r    <= reg_addr_t'(0);
      wb_data_r  <= data_t'(0);
    end else begin
      wb_valid_r <= bus.mem_valid & bus.mem_reg_write;
      wb_rd_r    <= bus.mem_rd;
      wb_data_r  <= wb_select(bus.mem_to_reg, bus.mem_load_data, bus.mem_alu_result);
    end
  end

  // Operand hazards, optional write-back bypass, and issue throttling.
  always_comb begin
`ifdef WB_BYPASS_EN
    fwd_a_s = wb_valid_r && (wb_rd_r == bus.rs) && cnt_one_s[bus.rs];
    fwd_b_s = wb_valid_r && (wb_rd_r == bus.rd) && cnt_one_s[bus.rd];
`else
    fwd_a_s = 1'b0;
    fwd_b_s = 1'b0;
`endif
    haz_s_s       = bus.rs_used && cnt_nz_s[bus.rs] && !fwd_a_s;
    haz_d_s       = bus.rd_used && cnt_nz_s[bus.rd] && !fwd_b_s;
    stall_s       = haz_s_s || haz_d_s;
    issue_ready_s = !cnt_max_s[bus.issue_rd] || (wb_valid_r && (wb_rd_r == bus.issue_rd));
    issue_fire_s  = bus.issue_valid && bus.issue_reg_write && issue_ready_s && !stall_s;
  end

  pending_counter_bank u_counters (
    .clock    (clock),
    .reset    (reset),
    .clear    (bus.flush),
    .inc_en   (issue_fire_s),
    .inc_addr (bus.issue_rd),
    .dec_en   (wb_valid_r),
    .dec_addr (wb_rd_r),
    .cnt_nz   (cnt_nz_s),
    .cnt_one  (cnt_one_s),
    .cnt_max  (cnt_max_s)
  );

  reg_writeback_unit_checker u_checker (
    .clock             (clock),
    .reset             (reset),
    .flush             (bus.flush),
    .op_reg_write      (wb_valid_r),
    .address_for_write (wb_rd_r),
    .cnt_nz            (cnt_nz_s)
  );

  assign bus.op_reg_write      = wb_valid_r;
  assign bus.address_for_write = wb_rd_r;
  assign bus.data_for_write    = wb_data_r;
  assign bus.stall             = stall_s;
  assign bus.issue_ready       = issue_ready_s;
  assign bus.fwd_a             = fwd_a_s;
  assign bus.fwd_b             = fwd_b_s;

endmodule
